// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU (MEM stage) has priority over a DMA/loader port,
// with a starvation counter that forces a DMA grant, and routes RAM read data back.
module dmem_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          clrn,
   // CPU port
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_stall,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_rvalid,
   // DMA port
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_rvalid,
   // RAM side
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_datain,
   input  logic [DW-1:0] mem_dataout
);

   localparam int unsigned CW = 3;
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   typedef enum logic [1:0] {
      RD_NONE = 2'd0,
      RD_CPU  = 2'd1,
      RD_DMA  = 2'd2
   } rd_owner_t;

   logic [CW-1:0] r_starve_cnt;
   logic [CW-1:0] w_starve_nxt;
   rd_owner_t     r_rd_owner;
   rd_owner_t     w_rd_owner_nxt;
   logic          w_starved;
   logic          w_dma_gnt;
   logic          w_cpu_gnt;

   // Same-cycle grant; DMA wins only when the CPU is idle or the DMA is starved
   assign w_starved = (r_starve_cnt == STARVE_LIM);
   assign w_dma_gnt = dma_req & (~cpu_req | w_starved) & ~clrn;
   assign w_cpu_gnt = cpu_req & ~w_dma_gnt & ~clrn;

   assign dma_gnt   = w_dma_gnt;
   assign cpu_stall = cpu_req & w_dma_gnt;

   // RAM drive mux; write enable only ever follows a grant
   always_comb begin
      mem_we     = 1'b0;
      mem_addr   = cpu_addr;
      mem_datain = cpu_wdata;
      if (w_dma_gnt) begin
         mem_we     = dma_we;
         mem_addr   = dma_addr;
         mem_datain = dma_wdata;
      end else if (w_cpu_gnt) begin
         mem_we     = cpu_we;
      end
   end

   // Consecutive DMA denials, saturating at the forced-grant threshold
   always_comb begin
      w_starve_nxt = r_starve_cnt;
      if (w_dma_gnt || !dma_req) begin
         w_starve_nxt = '0;
      end else if (w_cpu_gnt && !w_starved) begin
         w_starve_nxt = r_starve_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clrn) begin
         r_starve_cnt <= '0;
      end else begin
         r_starve_cnt <= w_starve_nxt;
      end
   end

   // Read-return owner: remembers which port issued the read now in flight
   always_ff @(posedge clk) begin
      if (clrn) begin
         r_rd_owner <= RD_NONE;
      end else begin
         r_rd_owner <= w_rd_owner_nxt;
      end
   end

   always_comb begin
      w_rd_owner_nxt = RD_NONE;
      if (w_dma_gnt && !dma_we) begin
         w_rd_owner_nxt = RD_DMA;
      end else if (w_cpu_gnt && !cpu_we) begin
         w_rd_owner_nxt = RD_CPU;
      end
   end

   // A read in flight when reset arrives must not surface a valid
   assign cpu_rvalid = (r_rd_owner == RD_CPU) & ~clrn;
   assign dma_rvalid = (r_rd_owner == RD_DMA) & ~clrn;
   assign cpu_rdata  = mem_dataout;
   assign dma_rdata  = mem_dataout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 1-cycle-latency synchronous RAM model.
module tb_dmem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clk;
   logic          clrn;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_stall;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_rvalid;
   logic          dma_req, dma_we;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata;
   logic          dma_gnt;
   logic [DW-1:0] dma_rdata;
   logic          dma_rvalid;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_datain;
   logic [DW-1:0] mem_dataout;

   int n_checks = 0;
   int n_fail   = 0;

   dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
      .clk        (clk),
      .clrn       (clrn),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_stall  (cpu_stall),
      .cpu_rdata  (cpu_rdata),
      .cpu_rvalid (cpu_rvalid),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_gnt    (dma_gnt),
      .dma_rdata  (dma_rdata),
      .dma_rvalid (dma_rvalid),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_datain (mem_datain),
      .mem_dataout(mem_dataout)
   );

   // Synchronous single-port RAM, read data one cycle after the address
   logic [DW-1:0] ram [0:255];
   always_ff @(posedge clk) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_datain;
      mem_dataout <= ram[mem_addr[7:0]];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One cycle: drive inputs on the falling edge, settle, then caller checks
   task automatic cyc(input logic rst,
                      input logic creq, input logic cwe, input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                      input logic dreq, input logic dwe, input logic [AW-1:0] daddr, input logic [DW-1:0] dwd);
      @(negedge clk);
      clrn      = rst;
      cpu_req   = creq;
      cpu_we    = cwe;
      cpu_addr  = caddr;
      cpu_wdata = cwd;
      dma_req   = dreq;
      dma_we    = dwe;
      dma_addr  = daddr;
      dma_wdata = dwd;
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   logic exp_g, exp_crv, exp_drv;

   initial begin
      clrn = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

      // Reset with both ports requesting writes: nothing may be granted or written
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 1'b1, 1'b1, 32'h10, 32'h0BAD, 1'b1, 1'b1, 32'h20, 32'h0BAD);
         check_eq("rst_dma_gnt", dma_gnt, 0);
         check_eq("rst_cpu_stall", cpu_stall, 0);
         check_eq("rst_mem_we", mem_we, 0);
         check_eq("rst_cpu_rvalid", cpu_rvalid, 0);
         check_eq("rst_dma_rvalid", dma_rvalid, 0);
         check_eq("rst_starve_cnt", dut.r_starve_cnt, 0);
      end

      // CPU write then read
      cyc(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
      check_eq("cw_mem_we", mem_we, 1);
      check_eq("cw_mem_addr", mem_addr, 32'h10);
      check_eq("cw_mem_datain", mem_datain, 32'hDEADBEEF);
      check_eq("cw_stall", cpu_stall, 0);
      cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      check_eq("cr_mem_we", mem_we, 0);
      check_eq("cr_stall", cpu_stall, 0);
      check_eq("cr_rvalid_early", cpu_rvalid, 0);
      idle();
      check_eq("cr_rvalid", cpu_rvalid, 1);
      check_eq("cr_rdata", cpu_rdata, 32'hDEADBEEF);
      check_eq("cr_mem_we_idle", mem_we, 0);
      idle();
      check_eq("cr_rvalid_once", cpu_rvalid, 0);

      // DMA write then read with CPU idle
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678);
      check_eq("dw_gnt", dma_gnt, 1);
      check_eq("dw_mem_we", mem_we, 1);
      check_eq("dw_mem_addr", mem_addr, 32'h20);
      check_eq("dw_mem_datain", mem_datain, 32'h12345678);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      check_eq("dr_gnt", dma_gnt, 1);
      check_eq("dr_mem_we", mem_we, 0);
      idle();
      check_eq("dr_rvalid", dma_rvalid, 1);
      check_eq("dr_rdata", dma_rdata, 32'h12345678);
      check_eq("dr_cpu_rvalid", cpu_rvalid, 0);
      idle();
      check_eq("dr_rvalid_once", dma_rvalid, 0);

      // Continuous dual requests: DMA forced in every fifth cycle
      for (int i = 1; i <= 15; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
         exp_g   = (i % 5 == 0);
         exp_crv = (i > 1) && ((i - 1) % 5 != 0);
         exp_drv = (i > 1) && ((i - 1) % 5 == 0);
         check_eq($sformatf("arb%0d_dma_gnt", i), dma_gnt, exp_g);
         check_eq($sformatf("arb%0d_cpu_stall", i), cpu_stall, exp_g);
         check_eq($sformatf("arb%0d_starve", i), dut.r_starve_cnt, 32'((i - 1) % 5));
         check_eq($sformatf("arb%0d_mem_addr", i), mem_addr, exp_g ? 32'h20 : 32'h10);
         check_eq($sformatf("arb%0d_cpu_rvalid", i), cpu_rvalid, exp_crv);
         check_eq($sformatf("arb%0d_dma_rvalid", i), dma_rvalid, exp_drv);
         if (exp_crv) check_eq($sformatf("arb%0d_cpu_rdata", i), cpu_rdata, 32'hDEADBEEF);
         if (exp_drv) check_eq($sformatf("arb%0d_dma_rdata", i), dma_rdata, 32'h12345678);
      end
      idle();
      check_eq("arb_tail_dma_rvalid", dma_rvalid, 1);
      check_eq("arb_tail_starve", dut.r_starve_cnt, 0);
      idle();

      // CPU read then DMA read back-to-back, each gets its own data
      cyc(1'b0, 1'b1, 1'b1, 32'h30, 32'hAAAA5555, 1'b0, 1'b0, 32'h0, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h5A5A1234);
      cyc(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      check_eq("b2b1_cpu_rvalid", cpu_rvalid, 0);
      check_eq("b2b1_dma_rvalid", dma_rvalid, 0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
      check_eq("b2b2_dma_gnt", dma_gnt, 1);
      check_eq("b2b2_cpu_rvalid", cpu_rvalid, 1);
      check_eq("b2b2_dma_rvalid", dma_rvalid, 0);
      check_eq("b2b2_cpu_rdata", cpu_rdata, 32'hAAAA5555);
      idle();
      check_eq("b2b3_cpu_rvalid", cpu_rvalid, 0);
      check_eq("b2b3_dma_rvalid", dma_rvalid, 1);
      check_eq("b2b3_dma_rdata", dma_rdata, 32'h5A5A1234);
      idle();

      // DMA read granted, then reset: the in-flight read is discarded
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      check_eq("rmid_gnt", dma_gnt, 1);
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 1'b1, 1'b1, 32'h50, 32'h77, 1'b1, 1'b1, 32'h60, 32'h77);
         check_eq($sformatf("rmid%0d_dma_rvalid", i), dma_rvalid, 0);
         check_eq($sformatf("rmid%0d_cpu_rvalid", i), cpu_rvalid, 0);
         check_eq($sformatf("rmid%0d_dma_gnt", i), dma_gnt, 0);
         check_eq($sformatf("rmid%0d_cpu_stall", i), cpu_stall, 0);
         check_eq($sformatf("rmid%0d_mem_we", i), mem_we, 0);
      end
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      check_eq("rpost_gnt", dma_gnt, 1);
      check_eq("rpost_dma_rvalid", dma_rvalid, 0);
      check_eq("rpost_starve", dut.r_starve_cnt, 0);
      idle();
      check_eq("rpost_rvalid", dma_rvalid, 1);
      check_eq("rpost_rdata", dma_rdata, 32'h12345678);
      idle();

      // DMA drops its request after 3 denials: counter restarts from zero
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
         check_eq($sformatf("drop_pre%0d_gnt", i), dma_gnt, 0);
         check_eq($sformatf("drop_pre%0d_starve", i), dut.r_starve_cnt, 32'(i));
      end
      cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h20, 32'h0);
      check_eq("drop_gap_gnt", dma_gnt, 0);
      check_eq("drop_gap_starve", dut.r_starve_cnt, 3);
      for (int j = 1; j <= 5; j++) begin
         cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
         check_eq($sformatf("drop_post%0d_gnt", j), dma_gnt, (j == 5) ? 1 : 0);
         check_eq($sformatf("drop_post%0d_stall", j), cpu_stall, (j == 5) ? 1 : 0);
         check_eq($sformatf("drop_post%0d_starve", j), dut.r_starve_cnt, 32'(j - 1));
      end
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
